// File: rtl/calc_pkg.sv
// Shared definitions for the calc datapath and its input conditioning stage.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    PEND_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    PEND_LOW  = 2'd3
  } deb_state_t;

  localparam int DATA_W = 16;

  // Op-button bit order {btnl, btnc, btnr}; calc decodes opcodes with the same indices.
  localparam int OP_W = 3;
  localparam int OP_L = 2;
  localparam int OP_C = 1;
  localparam int OP_R = 0;

  // The accepted level is high while settled high or while a fall is still unconfirmed.
  function automatic logic deb_level(input deb_state_t st);
    return (st == IDLE_HIGH) || (st == PEND_LOW);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw button: multi-stage synchroniser followed by a counted debounce FSM.
module btn_debounce
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  deb_state_t             state_r, state_s;
  logic [CNT_W-1:0]       cnt_r, cnt_s;
  logic                   stable_r;

  assign sync_s = sync_r[SYNC_STAGES-1];
  assign stable = stable_r;

  // Synchroniser shift chain for the raw asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
    end
  end

  // Next state: a change is accepted only after an unbroken run of DEBOUNCE_CYCLES samples.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE_LOW: begin
        if (sync_s) begin
          state_s = PEND_HIGH;
          cnt_s   = CNT_ONE;
        end else begin
          state_s = IDLE_LOW;
          cnt_s   = CNT_ZERO;
        end
      end
      PEND_HIGH: begin
        if (!sync_s) begin
          state_s = IDLE_LOW;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_s = IDLE_HIGH;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = PEND_HIGH;
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!sync_s) begin
          state_s = PEND_LOW;
          cnt_s   = CNT_ONE;
        end else begin
          state_s = IDLE_HIGH;
          cnt_s   = CNT_ZERO;
        end
      end
      PEND_LOW: begin
        if (sync_s) begin
          state_s = IDLE_HIGH;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_s = IDLE_LOW;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = PEND_LOW;
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE_LOW;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and registered stable level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE_LOW;
      cnt_r    <= CNT_ZERO;
      stable_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      stable_r <= deb_level(state_s);
    end
  end

endmodule

// File: rtl/calc_input_cond.sv
// Input conditioning for calc: debounced buttons, one-cycle update pulse and a
// coherent snapshot of op buttons and switches taken on that pulse.
module calc_input_cond
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic              clk,
  input  logic              btnu,
  input  logic              btnl,
  input  logic              btnc,
  input  logic              btnr,
  input  logic              btnd,
  input  logic [DATA_W-1:0] sw,
  output logic              btnd_pulse,
  output logic              btnl_q,
  output logic              btnc_q,
  output logic              btnr_q,
  output logic [DATA_W-1:0] sw_q
);

  logic [OP_W-1:0]                    op_stable_s;
  logic                               btnd_stable_s;
  logic                               btnd_prev_r;
  logic                               pulse_r;
  logic                               rise_s;
  logic [OP_W-1:0]                    op_q_r;
  logic [DATA_W-1:0]                  sw_q_r;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] sw_sync_r;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_deb_l (
    .clk(clk), .rst(btnu), .din(btnl), .stable(op_stable_s[OP_L]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_deb_c (
    .clk(clk), .rst(btnu), .din(btnc), .stable(op_stable_s[OP_C]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_deb_r (
    .clk(clk), .rst(btnu), .din(btnr), .stable(op_stable_s[OP_R]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_deb_d (
    .clk(clk), .rst(btnu), .din(btnd), .stable(btnd_stable_s));

  assign rise_s     = btnd_stable_s & ~btnd_prev_r;
  assign btnd_pulse = pulse_r;
  assign btnl_q     = op_q_r[OP_L];
  assign btnc_q     = op_q_r[OP_C];
  assign btnr_q     = op_q_r[OP_R];
  assign sw_q       = sw_q_r;

  // Per-bit switch synchroniser; switches are not debounced.
  always_ff @(posedge clk or posedge btnu) begin
    if (btnu) begin
      sw_sync_r <= {SYNC_STAGES{{DATA_W{1'b0}}}};
    end else begin
      sw_sync_r <= {sw_sync_r[SYNC_STAGES-2:0], sw};
    end
  end

  // Rising-edge pulse and snapshot; the snapshot uses the op levels registered before this edge.
  always_ff @(posedge clk or posedge btnu) begin
    if (btnu) begin
      btnd_prev_r <= 1'b0;
      pulse_r     <= 1'b0;
      op_q_r      <= {OP_W{1'b0}};
      sw_q_r      <= {DATA_W{1'b0}};
    end else begin
      btnd_prev_r <= btnd_stable_s;
      pulse_r     <= rise_s;
      if (rise_s) begin
        op_q_r <= op_stable_s;
        sw_q_r <= sw_sync_r[SYNC_STAGES-1];
      end
    end
  end

endmodule

// File: tb/tb_calc_input_cond.sv
// Directed and randomised bench for calc_input_cond against a history-based reference model.
module tb_calc_input_cond;

  localparam int DEB = 4;
  localparam int SYN = 2;

  logic        clk = 1'b0;
  logic        btnu, btnl, btnc, btnr, btnd;
  logic [15:0] sw;
  logic        btnd_pulse, btnl_q, btnc_q, btnr_q;
  logic [15:0] sw_q;

  int checks = 0;
  int passes = 0;

  // Reference model: raw history per post-reset edge, run-length debounce.
  logic [3:0]  btn_hist [0:8191];
  logic [15:0] sw_hist  [0:8191];
  int          k;
  logic [3:0]  m_stable;
  int          m_run [4];
  logic        m_prev, m_pulse;
  logic [2:0]  m_opq;
  logic [15:0] m_swq;

  int sc_step, pulse_cnt, first_pulse;

  always #5 clk = ~clk;

  calc_input_cond #(.DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYN)) dut (
    .clk(clk), .btnu(btnu), .btnl(btnl), .btnc(btnc), .btnr(btnr), .btnd(btnd),
    .sw(sw), .btnd_pulse(btnd_pulse), .btnl_q(btnl_q), .btnc_q(btnc_q),
    .btnr_q(btnr_q), .sw_q(sw_q));

  task automatic model_reset();
    k        = 0;
    m_stable = 4'b0000;
    for (int b = 0; b < 4; b++) m_run[b] = 0;
    m_prev   = 1'b0;
    m_pulse  = 1'b0;
    m_opq    = 3'b000;
    m_swq    = 16'h0000;
  endtask

  // Bits of btn_hist: {btnd, btnl, btnc, btnr}. The logic sees raw input SYN edges late.
  task automatic model_edge();
    logic [3:0]  samp;
    logic [15:0] sw_s;
    samp    = (k >= SYN) ? btn_hist[k-SYN] : 4'b0000;
    sw_s    = (k >= SYN) ? sw_hist[k-SYN]  : 16'h0000;
    m_pulse = m_stable[3] & ~m_prev;
    m_prev  = m_stable[3];
    if (m_pulse) begin
      m_opq = m_stable[2:0];
      m_swq = sw_s;
    end
    for (int b = 0; b < 4; b++) begin
      if (samp[b] == m_stable[b]) begin
        m_run[b] = 0;
      end else begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_stable[b] = ~m_stable[b];
          m_run[b]    = 0;
        end
      end
    end
    btn_hist[k] = {btnd, btnl, btnc, btnr};
    sw_hist[k]  = sw;
    k++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("btnd_pulse", {31'd0, btnd_pulse}, {31'd0, m_pulse});
    chk("btnl_q", {31'd0, btnl_q}, {31'd0, m_opq[2]});
    chk("btnc_q", {31'd0, btnc_q}, {31'd0, m_opq[1]});
    chk("btnr_q", {31'd0, btnr_q}, {31'd0, m_opq[0]});
    chk("sw_q", {16'd0, sw_q}, {16'd0, m_swq});
    if (btnd_pulse === 1'b1) begin
      pulse_cnt++;
      if (first_pulse < 0) first_pulse = sc_step;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (btnu !== 1'b1) model_edge();
    sc_step++;
    #1;
    check_outputs();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic begin_scen();
    sc_step     = 0;
    pulse_cnt   = 0;
    first_pulse = -1;
  endtask

  task automatic do_reset(input int n);
    btnu = 1'b1;
    model_reset();
    #1;
    check_outputs();
    steps(n);
    btnu = 1'b0;
  endtask

  task automatic half_pulse();
    @(negedge clk);
    btnd = 1'b1;
    step();
    btnd = 1'b0;
  endtask

  initial begin
    int hold;
    begin_scen();
    // 1: reset with all raw inputs high
    btnu = 1'b1; btnl = 1'b1; btnc = 1'b1; btnr = 1'b1; btnd = 1'b1; sw = 16'hffff;
    model_reset();
    steps(2);
    btnu = 1'b0;
    begin_scen();
    steps(12);
    chk("rst_pulse_cnt", pulse_cnt, 1);
    chk("rst_latency", first_pulse, 7);
    chk("rst_sw_q", {16'd0, sw_q}, 32'h0000ffff);
    chk("rst_ops_q", {29'd0, btnl_q, btnc_q, btnr_q}, 32'd7);

    // 2: clean press
    btnd = 1'b0; steps(10);
    btnl = 1'b0; btnc = 1'b1; btnr = 1'b1; sw = 16'h1234; btnd = 1'b1;
    begin_scen();
    steps(20);
    chk("clean_pulse_cnt", pulse_cnt, 1);
    chk("clean_latency", first_pulse, 7);
    chk("clean_sw_q", {16'd0, sw_q}, 32'h00001234);
    chk("clean_ops_q", {29'd0, btnl_q, btnc_q, btnr_q}, 32'd3);

    // 3: bounce 1,1,0,1,0 then steady 1 from step 6
    btnd = 1'b0; steps(10);
    begin_scen();
    btnd = 1'b1; step(); step();
    btnd = 1'b0; step();
    btnd = 1'b1; step();
    btnd = 1'b0; step();
    btnd = 1'b1; steps(15);
    chk("bounce_pulse_cnt", pulse_cnt, 1);
    chk("bounce_latency", first_pulse, 12);

    // 4: single-sample glitches never produce a pulse
    btnd = 1'b0; steps(10);
    sw = 16'h0ff0;
    begin_scen();
    for (int i = 0; i < 5; i++) begin
      half_pulse();
      steps(3);
    end
    steps(8);
    chk("glitch_pulse_cnt", pulse_cnt, 0);
    chk("glitch_sw_q", {16'd0, sw_q}, 32'h00001234);

    // 5: sw changes while btnd held are invisible until the next press
    btnd = 1'b1; sw = 16'h324f;
    begin_scen();
    steps(10);
    sw = 16'h2d31;
    steps(10);
    chk("hold_pulse_cnt", pulse_cnt, 1);
    chk("hold_sw_q", {16'd0, sw_q}, 32'h0000324f);
    btnd = 1'b0; steps(10);
    btnd = 1'b1;
    begin_scen();
    steps(10);
    chk("repress_pulse_cnt", pulse_cnt, 1);
    chk("repress_sw_q", {16'd0, sw_q}, 32'h00002d31);

    // 6: reset while btnd is pending (cnt = 2), btnd still held
    btnd = 1'b0; steps(10);
    btnd = 1'b1;
    begin_scen();
    steps(4);
    do_reset(1);
    chk("midrst_pulse_cnt", pulse_cnt, 0);
    begin_scen();
    steps(14);
    chk("midrst_after_cnt", pulse_cnt, 1);
    chk("midrst_latency", first_pulse, 7);

    // Randomised run: bursty btnd, toggling ops and switches, occasional reset
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        btnd = 1'($urandom_range(0, 1));
        hold = int'($urandom_range(1, 12));
      end
      hold--;
      if ($urandom_range(0, 7) == 0) btnl = ~btnl;
      if ($urandom_range(0, 7) == 0) btnc = ~btnc;
      if ($urandom_range(0, 7) == 0) btnr = ~btnr;
      if ($urandom_range(0, 15) == 0) sw = 16'($urandom);
      if ($urandom_range(0, 249) == 0) do_reset(1);
      else step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/calc_input_cond.md
# calc_input_cond

Input conditioning stage placed directly upstream of the `calc` accumulator block. It synchronises and debounces the raw operation buttons (`btnl`, `btnc`, `btnr`) and the update button (`btnd`), and turns each accepted `btnd` press into a single-cycle update pulse. It also captures a coherent snapshot of the operation buttons and `sw[15:0]` on that pulse, so `calc` never sees a torn operand or opcode.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples required to accept a level change; ≥ 2. Board builds use 1_000_000.
- `SYNC_STAGES`, default 2: flip-flop stages per raw input; ≥ 2.
- `clk` input 1: system clock; all logic on the rising edge.
- `btnu` input 1: reset. **One clock; reset is asynchronous and active-high.**
- `btnl`, `btnc`, `btnr` input 1 each: raw, asynchronous, bouncy operation buttons.
- `btnd` input 1: raw update button.
- `sw` input 16: raw switches; synchronised only, not debounced.
- `btnd_pulse` output 1: one-cycle pulse per accepted `btnd` press.
- `btnl_q`, `btnc_q`, `btnr_q` output 1 each: debounced op levels captured on the pulse.
- `sw_q` output 16: synchronised `sw` captured on the pulse.

## Operation
- **Synchronisers.** Each raw input passes through `SYNC_STAGES` flip-flops. `sw` uses a per-bit synchroniser of the same depth.
- **Debouncer per button.** Each button has an FSM with states IDLE_LOW, PEND_HIGH, IDLE_HIGH and PEND_LOW, plus a counter `cnt`.
  - IDLE_x: if the synchronised input differs from the stable level, go to PEND_y with `cnt` = 1. Otherwise stay.
  - PEND_y, input equals the new level: `cnt` increments. When `cnt` == `DEBOUNCE_CYCLES`, go to IDLE_y (the stable level flips) and clear `cnt`.
  - PEND_y, input returns to the old level: abort to IDLE_x and clear `cnt`. There is no partial credit.
- **Counter width.** `cnt` width is $clog2(`DEBOUNCE_CYCLES`+1). It never wraps, because it saturates at the transition.
- **Edge detection.** Edge detect applies only to the stable `btnd`: a 0→1 transition of stable `btnd` registers `btnd_pulse` = 1 for exactly one cycle.
  - A held button gives one pulse.
  - A second pulse requires the release to be debounced first (IDLE_LOW), then a new press.
- **Snapshot.** On the same edge that sets `btnd_pulse`, load the current values into the outputs:
  - stable `btnl`/`btnc`/`btnr` → `btnl_q`/`btnc_q`/`btnr_q`;
  - synchronised `sw` → `sw_q`.
  
  The outputs hold until the next pulse. Op-button changes between presses are invisible downstream.
- **Simultaneous events.** If an op button's stable level flips on the same edge that the `btnd` pulse is generated, the snapshot takes the pre-flip stable value, i.e. the registered value.
- **Reset.** Reset clears all synchroniser flops, puts all FSMs in IDLE_LOW with `cnt` = 0, and sets `btnd_pulse` = 0, `btnl_q` = `btnc_q` = `btnr_q` = 0 and `sw_q` = 16'h0000.
  - Reset asserted mid-PEND discards the pending change.
  - A `btnd` held across reset release is debounced afresh and produces exactly one pulse.

## Timing
- **Latency.** Let edge E be the first rising edge at which raw `btnd` = 1 is sampled and stays high. `btnd_pulse` is high in the cycle after edge E + `SYNC_STAGES` + `DEBOUNCE_CYCLES`. Total: `SYNC_STAGES` + `DEBOUNCE_CYCLES` + 1 edges. With the defaults that is 19 cycles.
- **Release.** Release debounce takes the same latency and generates no pulse.
- **Pulse coherence.** `btnd_pulse` is always exactly 1 cycle wide. The `_q` outputs change only on the edge that raises `btnd_pulse`, so they are valid in the same cycle as the pulse.
- **Glitch rejection.** Raw glitches shorter than `DEBOUNCE_CYCLES` synchronised cycles never reach any output.
- **Reset timing.** Reset acts immediately, with no clock needed. Outputs are 0 from reset assertion until at least latency cycles after release.

## Structure
- **Shared package `calc_pkg`:**
  - `deb_state_t` enum (IDLE_LOW, PEND_HIGH, IDLE_HIGH, PEND_LOW);
  - `DATA_W` = 16;
  - op-button bit-order constant {`btnl`, `btnc`, `btnr`}, shared with `calc`.
- **Sub-module `btn_debounce`:** synchroniser, FSM and counter for one button, outputting its stable level. It is instantiated 4 times.
- **Top level:** edge detect, snapshot registers and the `sw` synchroniser.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 and `SYNC_STAGES` = 2, giving a latency of 7.
1. **Reset.** Raw inputs all 1, `sw` = 16'hffff, `btnu` high for 2 cycles → all outputs 0 throughout reset. After release, exactly one `btnd_pulse` 7 cycles later, with `sw_q` = 16'hffff and `btnl_q` = `btnc_q` = `btnr_q` = 1.
2. **Clean press.** `btnl` = 0, `btnc` = 1, `btnr` = 1, `sw` = 16'h1234, `btnd` held for 20 cycles → one pulse at latency 7. `sw_q` = 16'h1234, `btnc_q` = 1, `btnr_q` = 1, `btnl_q` = 0. No second pulse.
3. **Bounce.** `btnd` pattern 1,1,0,1,0,1 then steady 1 → single pulse 7 cycles after the start of the steady run. No earlier pulse.
4. **Sub-debounce pulse.** Half-cycle `btnd` pulses, as the `calc` bench drives them, with `sw` = 16'h0ff0 → no pulse. `sw_q` keeps its previous value.
5. **Hold between presses.** Press with `sw` = 16'h324f, then change `sw` to 16'h2d31 while `btnd` is still held → `sw_q` stays 16'h324f. After release, a new press gives `sw_q` = 16'h2d31.
6. **Reset mid-operation.** `btnu` pulsed while `btnd` is in PEND_HIGH (cnt = 2), `btnd` still held → no pulse during reset. Exactly one pulse 7 cycles after the first post-reset edge.
